vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: free-running horizontal/vertical counters with configurable active, porch and sync lengths and polarities. It drives hSync/vSync, a display-enable and line/frame strobes, delayed by a configurable pipeline depth so they align with a downstream pixel pipeline. It replaces the fixed 640x480 `VGA` timing core and sits between the pixel-clock domain and the framebuffer read path.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_delay_line.sv | 22 ++
 rtl/vga_timing_gen.sv | 78 +++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, decoded-output bundle, idle levels and sizing helpers
package vga_timing_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit DEF_H_POL = 1'b0;
  localparam bit DEF_V_POL = 1'b0;
  localparam int DEF_PIPE_DELAY = 1;
  localparam int DEF_FC_W = 16;
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } vga_dec_t;
  function automatic int seg_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  function automatic int seg_width(input int a, input int b, input int c, input int d);
    return $clog2(seg_total(a, b, c, d));
  endfunction
  function automatic vga_dec_t idle_dec(input bit h_pol, input bit v_pol);
    return '{hs: ~h_pol, vs: ~v_pol, de: 1'b0, ls: 1'b0, fs: 1'b0};
  endfunction
endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster coordinates and decoded timing outputs; frame_count only with VGA_TIMING_FRAME_COUNT_EN
interface vga_timing_if
  import vga_timing_pkg::*;
#(
  parameter int HW = seg_width(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
  parameter int VW = seg_width(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP)
`ifdef VGA_TIMING_FRAME_COUNT_EN
  , parameter int FC_W = DEF_FC_W
`endif
);
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic hSync;
  logic vSync;
  logic active;
  logic line_start;
  logic frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [FC_W-1:0] frame_count;
  modport master(output hcount, vcount, hSync, vSync, active, line_start, frame_start, frame_count);
  modport slave(input hcount, vcount, hSync, vSync, active, line_start, frame_start, frame_count);
`else
  modport master(output hcount, vcount, hSync, vSync, active, line_start, frame_start);
  modport slave(input hcount, vcount, hSync, vSync, active, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-deep ce-gated shift register whose stages all reset to INIT
module vga_delay_line #(
  parameter int W = 5,
  parameter int D = 1,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ce_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] stage_q [D];
  always_ff @(posedge clk)
    if (reset) begin
      for (int i = 0; i < D; i++) stage_q[i] <= INIT;
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < D; i++) stage_q[i] <= stage_q[i-1];
    end
  assign q_o = stage_q[D-1];
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with delayed decode; VGA_TIMING_FRAME_COUNT_EN adds frame_count
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit H_POL = DEF_H_POL,
  parameter bit V_POL = DEF_V_POL,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
`ifdef VGA_TIMING_FRAME_COUNT_EN
  , parameter int FC_W = DEF_FC_W
`endif
) (
  input logic clk,
  input logic reset,
  input logic ce,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = seg_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VW = seg_width(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC;
  localparam vga_dec_t IDLE = idle_dec(H_POL, V_POL);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic h_wrap, v_wrap;
  vga_dec_t dec_d, dec_q;
  always_comb begin
    h_wrap = h_q == HW'(H_TOTAL - 1);
    v_wrap = v_q == VW'(V_TOTAL - 1);
    h_d = h_wrap ? '0 : h_q + 1'b1;
    v_d = h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    dec_d.hs = (int'(h_q) >= HS_START && int'(h_q) < HS_END) ? H_POL : ~H_POL;
    dec_d.vs = (int'(v_q) >= VS_START && int'(v_q) < VS_END) ? V_POL : ~V_POL;
    dec_d.de = int'(h_q) < H_ACTIVE && int'(v_q) < V_ACTIVE;
    dec_d.ls = h_q == '0;
    dec_d.fs = h_q == '0 && v_q == '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (ce) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  vga_delay_line #(.W($bits(vga_dec_t)), .D(PIPE_DELAY), .INIT(IDLE)) u_dly (
    .clk(clk),
    .reset(reset),
    .ce_i(ce),
    .d_i(dec_d),
    .q_o(dec_q)
  );
  assign bus.hcount = h_q;
  assign bus.vcount = v_q;
  assign bus.hSync = dec_q.hs;
  assign bus.vSync = dec_q.vs;
  assign bus.active = dec_q.de;
  assign bus.line_start = dec_q.ls;
  assign bus.frame_start = dec_q.fs;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [FC_W-1:0] fc_q;
  always_ff @(posedge clk)
    if (reset) fc_q <= '0;
    else if (ce && h_wrap && v_wrap) fc_q <= fc_q + 1'b1;
  assign bus.frame_count = fc_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-timing vector table plus default-timing line checks for vga_timing_gen
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic ce_a = 1'b0;
  logic rst_b = 1'b1;
  logic ce_b = 1'b1;
  int tot = 0;
  int pass = 0;
  always #5 clk = ~clk;
  typedef struct {
    int k;
    int hc;
    int vc;
    bit hs;
    bit vs;
    bit de;
    bit ls;
    bit fs;
  } vec_t;
  vga_timing_if #(.HW(3), .VW(3)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .FC_W(2)
`endif
  ) bus_a ();
  vga_timing_if #(.HW(10), .VW(10)) bus_b ();
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DELAY(3)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .FC_W(2)
`endif
  ) dut_a (.clk(clk), .reset(rst_a), .ce(ce_a), .bus(bus_a));
  vga_timing_gen dut_b (.clk(clk), .reset(rst_b), .ce(ce_b), .bus(bus_b));
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [10:0] out_a();
    return {bus_a.hcount, bus_a.vcount, bus_a.hSync, bus_a.vSync, bus_a.active,
            bus_a.line_start, bus_a.frame_start};
  endfunction
  function automatic logic [4:0] dec_b();
    return {bus_b.hSync, bus_b.vSync, bus_b.active, bus_b.line_start, bus_b.frame_start};
  endfunction
  initial begin
    vec_t tbl[16];
    int k;
    int t_first;
    int t_second;
    int holds;
    int hs_lo;
    int hs_first;
    int de_cnt;
    int vs_lo;
    bit found;
    logic [10:0] pre;
    tbl[0]  = '{0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2,  2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3,  3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{4,  4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{6,  6, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{7,  7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{9,  1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{10, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{11, 3, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{29, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{35, 3, 4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{42, 2, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{43, 3, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{48, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{51, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rst_a = 1'b1;
    ce_a = 1'b1;
    tick();
    rst_a = 1'b0;
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        tick();
        k++;
      end
      chk($sformatf("vec_k%0d", tbl[i].k), 32'(out_a()),
          32'({3'(tbl[i].hc), 3'(tbl[i].vc), tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls, tbl[i].fs}));
    end
    rst_a = 1'b1;
    ce_a = 1'b1;
    tick();
    rst_a = 1'b0;
    t_first = -1;
    t_second = -1;
    holds = 0;
    for (int t = 0; t < 200; t++) begin
      ce_a = (t % 2 == 0);
      pre = out_a();
      if (ce_a && bus_a.frame_start) begin
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
      tick();
      if (!ce_a && out_a() !== pre) holds++;
    end
    chk("half_ce_first_fs", 32'(t_first), 32'd6);
    chk("half_ce_frame_period", 32'(t_second - t_first), 32'd96);
    chk("half_ce_hold", 32'(holds), 32'd0);
    ce_a = 1'b1;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    repeat (13) tick();
    chk("pre_rst_active", 32'(bus_a.active), 32'd1);
    rst_a = 1'b1;
    ce_a = 1'b0;
    tick();
    rst_a = 1'b0;
    chk("rst_ce_low", 32'(out_a()), 32'd0);
    ce_a = 1'b1;
    repeat (2) tick();
    chk("rst_ce_low_lag", 32'(bus_a.active), 32'd0);
    tick();
    chk("rst_ce_low_rise", 32'({bus_a.hcount, bus_a.active, bus_a.line_start, bus_a.frame_start}), 32'h1F);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("fc_reset", 32'(bus_a.frame_count), 32'd0);
    repeat (143) tick();
    chk("fc_143", 32'(bus_a.frame_count), 32'd2);
    tick();
    chk("fc_3_frames", 32'(bus_a.frame_count), 32'd3);
    repeat (48) tick();
    chk("fc_4_frames", 32'(bus_a.frame_count), 32'd0);
    chk("fc_b_reset", 32'(bus_b.frame_count), 32'd0);
`endif
    chk("b_reset_coord", 32'({bus_b.hcount, bus_b.vcount}), 32'd0);
    chk("b_reset_dec", 32'(dec_b()), 32'h18);
    rst_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (bus_b.hcount == 10'd300) found = 1'b1;
      else tick();
    end
    chk("b_wait_h300", 32'(found), 32'd1);
    chk("b_active_h300", 32'(bus_b.active), 32'd1);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("b_midline_rst_coord", 32'({bus_b.hcount, bus_b.vcount}), 32'd0);
    chk("b_midline_rst_dec", 32'(dec_b()), 32'h18);
    tick();
    chk("b_active_rise", 32'(dec_b()), 32'h1F);
    hs_first = -1;
    hs_lo = 0;
    de_cnt = 0;
    vs_lo = 0;
    for (int i = 0; i < 800; i++) begin
      if (!bus_b.hSync) begin
        if (hs_first < 0) hs_first = int'(bus_b.hcount);
        hs_lo++;
      end
      if (bus_b.active) de_cnt++;
      if (!bus_b.vSync) vs_lo++;
      tick();
    end
    chk("b_hsync_start", 32'(hs_first), 32'd657);
    chk("b_hsync_len", 32'(hs_lo), 32'd96);
    chk("b_active_len", 32'(de_cnt), 32'd640);
    chk("b_vsync_idle_line0", 32'(vs_lo), 32'd0);
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
